data_memory_ls: RTL

Byte-addressed RV32 load/store data memory that replaces the word-only data memory in the pipelined core. It decodes RISC-V `funct3` to write byte/halfword/word lanes and to sign- or zero-extend loads. It detects misaligned, out-of-range and illegal accesses and flags them with an error code. Accesses use a request/response handshake with a registered (synchronous) read, so it sits behind the core's MEM stage or a small bus adapter.

---
 rtl/data_memory_ls.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/data_memory_ls.sv
// Byte-addressed RV32 load/store data memory with a request/response
// handshake. Decodes funct3 into byte lanes and load extension, and reports
// illegal, misaligned and out-of-range accesses through resp_err.
module data_memory_ls #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_rdata,
    output logic [1:0]            resp_err
);
    localparam int          IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [63:0] BYTE_LIMIT = 64'(DEPTH_WORDS) << 2;

    typedef enum logic { S_IDLE, S_RESP } state_t;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } err_t;

    state_t state;

    // Contents start at zero and survive rst; only stores change them.
    logic [31:0] mem [DEPTH_WORDS] = '{default: '0};

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       offset;
    logic [4:0]       shamt;
    logic             accept;
    logic             illegal;
    logic             misaligned;
    logic             out_of_range;
    err_t             err_c;
    logic [3:0]       byte_en;
    logic [31:0]      wdata_sh;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shift;
    logic [31:0]      load_data;
    logic             write_en;

    assign word_idx  = req_addr[IDX_W+1:2];
    assign offset    = req_addr[1:0];
    assign shamt     = {offset, 3'b000};
    assign req_ready = (state == S_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign write_en  = accept && req_we && (err_c == ERR_OK);
    assign wdata_sh  = req_wdata << shamt;
    assign rd_word   = mem[word_idx];
    assign rd_shift  = rd_word >> shamt;

    // Classify the request, build the store lane mask and the extended load value.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        illegal      = 1'b1;
        misaligned   = 1'b0;
        out_of_range = 1'b0;
        err_c        = ERR_OK;
        byte_en      = 4'b1111;
        load_data    = '0;

        case (req_funct3)
            3'b000, 3'b001, 3'b010: illegal = 1'b0;
            3'b100, 3'b101:         illegal = req_we;
            default:                illegal = 1'b1;
        endcase

        case (req_funct3[1:0])
            2'b01:   misaligned = offset[0];
            2'b10:   misaligned = (offset != 2'b00);
            default: misaligned = 1'b0;
        endcase

        out_of_range = (64'(req_addr) >= BYTE_LIMIT);

        if (illegal)           err_c = ERR_ILLEGAL;
        else if (misaligned)   err_c = ERR_MISALIGN;
        else if (out_of_range) err_c = ERR_RANGE;
        else                   err_c = ERR_OK;

        case (req_funct3[1:0])
            2'b00:   byte_en = 4'b0001 << offset;
            2'b01:   byte_en = 4'b0011 << offset;
            default: byte_en = 4'b1111;
        endcase

        case (req_funct3)
            3'b000:  load_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_data = rd_word;
            3'b100:  load_data = {24'h0, rd_shift[7:0]};
            3'b101:  load_data = {16'h0, rd_shift[15:0]};
            default: load_data = '0;
        endcase
    end

    // Write the enabled byte lanes of the addressed word on the accept edge.
    // NOTE: the storage array has no reset; clearing it would defeat RAM inference and is not wanted.
    always_ff @(posedge clk) begin
        if (write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    // NOTE: sequential state uses non-blocking assignment so all flops update together.
                    mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // Two-state handshake FSM that registers and holds the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= ERR_OK;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= err_c;
                        resp_rdata <= (req_we || err_c != ERR_OK) ? 32'h0 : load_data;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        state      <= S_IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
